// File: rtl/perf_counter_bank.sv
// -----------------------------------------------------------------------------
// perf_counter_bank
//
// Parametrised bank of NUM_CNT single-bit event counters for pipeline
// statistics: cycles, stalls, loads, stores, ALU ops, control ops.
// The bank has these features:
//   - a global count enable
//   - a synchronous clear of the live counters and the overflow flags
//   - an atomic snapshot into shadow registers (snap + clear = read-and-reset)
//   - sticky overflow flags
//   - wrap or saturate at the maximum count (SATURATE)
//   - an indexed read port with a one-cycle registered latency
//
// Parameters:
//   NUM_CNT   number of counters / event inputs (1..2**IDX_W)
//   CNT_WIDTH counter width in bits (2..64)
//   IDX_W     read-index width (2**IDX_W >= NUM_CNT)
//   SATURATE  0 = wrap to 0 at max, 1 = hold at max
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   cnt_en     global count enable; 0 freezes every live counter
//   evt_in     per-counter event, bit i adds 1 to counter i
//   clear      synchronous clear of live counters and ovf_flags
//   snap       copy all live counters (pre-edge values) into the shadows
//   rd_en      read request
//   rd_idx     counter index to read (index >= NUM_CNT reads as 0)
//   rd_src     0 = live counter, 1 = shadow
//   rd_data    registered read data, holds while rd_en is low
//   rd_valid   high the cycle after rd_en
//   ovf_flags  sticky per-counter overflow flags
//   snap_valid set by the first snap after reset
//
// Optional feature, enabled by defining PERF_CNT_IRQ_EN:
//   irq_mask   (in)  per-counter overflow interrupt mask
//   ovf_irq    (out) registered OR of (ovf_flags & irq_mask), one cycle behind
// -----------------------------------------------------------------------------
module perf_counter_bank #(
   parameter int NUM_CNT   = 8,
   parameter int CNT_WIDTH = 32,
   parameter int IDX_W     = 3,
   parameter int SATURATE  = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cnt_en,
   input  logic [NUM_CNT-1:0]   evt_in,
   input  logic                 clear,
   input  logic                 snap,
   input  logic                 rd_en,
   input  logic [IDX_W-1:0]     rd_idx,
   input  logic                 rd_src,
   output logic [CNT_WIDTH-1:0] rd_data,
   output logic                 rd_valid,
   output logic [NUM_CNT-1:0]   ovf_flags,
   output logic                 snap_valid
`ifdef PERF_CNT_IRQ_EN
   ,
   input  logic [NUM_CNT-1:0]   irq_mask,
   output logic                 ovf_irq
`endif
);

   // Every encodable read index gets a slot; slots beyond NUM_CNT are tied
   // to zero so an out-of-range read returns 0 without a bounds compare.
   localparam int NUM_SLOT = 1 << IDX_W;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   logic [CNT_WIDTH-1:0] live_slot   [NUM_SLOT];
   logic [CNT_WIDTH-1:0] shadow_slot [NUM_SLOT];

   logic [CNT_WIDTH-1:0] rd_data_reg;
   logic                 rd_valid_reg;
   logic                 snap_valid_reg;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SLOT; gi++) begin : g_cnt
         if (gi < NUM_CNT) begin : g_live
            logic [CNT_WIDTH-1:0] cnt_reg;
            logic [CNT_WIDTH-1:0] cnt_next;
            logic [CNT_WIDTH-1:0] shadow_reg;
            logic                 ovf_reg;
            logic                 ovf_next;

            // Clear wins over a same-cycle event, and that event is dropped.
            always_comb begin
               cnt_next = cnt_reg;
               ovf_next = ovf_reg;
               if (clear) begin
                  cnt_next = '0;
                  ovf_next = 1'b0;
               end else if (cnt_en && evt_in[gi]) begin
                  if (cnt_reg == CNT_MAX) begin
                     ovf_next = 1'b1;
                     cnt_next = (SATURATE != 0) ? CNT_MAX : '0;
                  end else begin
                     cnt_next = cnt_reg + CNT_ONE;
                  end
               end
            end

            // The shadow samples cnt_reg, the value before this edge. A
            // same-cycle increment or clear therefore never reaches it.
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  cnt_reg    <= '0;
                  ovf_reg    <= 1'b0;
                  shadow_reg <= '0;
               end else begin
                  cnt_reg <= cnt_next;
                  ovf_reg <= ovf_next;
                  if (snap) begin
                     shadow_reg <= cnt_reg;
                  end
               end
            end

            assign live_slot[gi]   = cnt_reg;
            assign shadow_slot[gi] = shadow_reg;
            assign ovf_flags[gi]   = ovf_reg;
         end else begin : g_empty
            assign live_slot[gi]   = '0;
            assign shadow_slot[gi] = '0;
         end
      end
   endgenerate

   // Read port: one result per cycle; data holds while no read is issued.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_reg    <= '0;
         rd_valid_reg   <= 1'b0;
         snap_valid_reg <= 1'b0;
      end else begin
         rd_valid_reg <= rd_en;
         if (rd_en) begin
            rd_data_reg <= rd_src ? shadow_slot[rd_idx] : live_slot[rd_idx];
         end
         if (snap) begin
            snap_valid_reg <= 1'b1;
         end
      end
   end

   assign rd_data    = rd_data_reg;
   assign rd_valid   = rd_valid_reg;
   assign snap_valid = snap_valid_reg;

`ifdef PERF_CNT_IRQ_EN
   // Registered from the flags, so the interrupt lags a flag by one cycle.
   // It also drops one cycle after a clear.
   logic ovf_irq_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_irq_reg <= 1'b0;
      end else begin
         ovf_irq_reg <= |(ovf_flags & irq_mask);
      end
   end

   assign ovf_irq = ovf_irq_reg;
`endif

endmodule

// File: doc/perf_counter_bank.md
Name: perf_counter_bank

Overview:
Parametrised bank of NUM_CNT event counters, successor to the fixed seven-counter pipeline statistics block. Counts single-bit pipeline events:
- cycles: tie an input high;
- stalls, loads, stores, ALU ops, control ops.

Adds a global enable, synchronous clear, atomic snapshot, sticky overflow flags, a wrap/saturate mode and an indexed registered read port. Sits beside the CPU core and is read by the testbench or a debug/MMIO front end.

Parameters:
NUM_CNT, 8, number of counters/event inputs (1..2**IDX_W)
CNT_WIDTH, 32, counter width in bits (2..64)
IDX_W, 3, read-index width; 2**IDX_W >= NUM_CNT required
SATURATE, 0, 0 = wrap at max, 1 = hold at max

Ports:
clk  in  1  clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
cnt_en  in  1  global count enable; 0 freezes all live counters
evt_in  in  NUM_CNT  per-counter event; bit i high = +1 to counter i this cycle
clear  in  1  synchronous clear of live counters and ovf_flags
snap  in  1  copy all live counters into shadow registers
rd_en  in  1  read request
rd_idx  in  IDX_W  counter index to read
rd_src  in  1  0 = live counter, 1 = shadow (snapshot)
rd_data  out  CNT_WIDTH  registered read data
rd_valid  out  1  high one cycle after rd_en
ovf_flags  out  NUM_CNT  sticky per-counter overflow flags
snap_valid  out  1  set by first snap after reset, cleared only by reset

Behaviour:
Interface: one clock (clk); reset is asynchronous and active-low (rst_n).

Reset (rst_n low, any time, including mid-read):
- live counters, shadows, ovf_flags, rd_data = 0;
- rd_valid = 0, snap_valid = 0.

Counting:
- Counter i increments by exactly 1 at an edge where cnt_en=1 and evt_in[i]=1.
- Increment result is visible the next cycle.
- All counters are independent; any subset may increment in the same cycle.

Overflow:
- Overflow = increment at value 2**CNT_WIDTH-1.
- SATURATE=0: counter wraps to 0.
- SATURATE=1: counter stays at max.
- In both modes ovf_flags[i] is set at that edge and remains set until clear or reset.

Clear:
- clear=1 forces all live counters and ovf_flags to 0 at the edge.
- clear has priority over same-cycle increments; the event is lost.
- Shadows are unaffected.

Snapshot:
- snap=1 loads every shadow with the live value held before the edge; same-cycle increments and clear are excluded.
- snap together with clear: shadows get pre-clear values and live counters become 0. This is the atomic read-and-reset.

Read port:
- rd_en=1 at edge N gives rd_data/rd_valid valid in cycle N+1 (1-cycle latency).
- Data is the selected register's value before edge N.
- rd_idx >= NUM_CNT returns 0 with rd_valid=1.
- rd_en=0: rd_valid=0 and rd_data holds its last value.
- Back-to-back reads give one result per cycle.

Width rules:
- All counter arithmetic is CNT_WIDTH-bit unsigned.
- No carry between counters.

Optional Feature:
PERF_CNT_IRQ_EN. Defined:
- adds input irq_mask [NUM_CNT-1:0] and output ovf_irq (1);
- ovf_irq is a registered OR of (ovf_flags & irq_mask) and lags the flag by one cycle;
- ovf_irq = 0 at reset and falls the cycle after clear.

Undefined: ports absent and no added logic; all other behaviour identical.

Test Plan:
Reset/count (NUM_CNT=4, CNT_WIDTH=8): release rst_n, cnt_en=1, evt_in=4'b0001 for 10 cycles, evt_in[1] on 3 of them -> reads idx0=10, idx1=3, idx2=0; rd_valid exactly one cycle after each rd_en.
Enable gating: evt_in=4'b1111 for 5 cycles with cnt_en=0, then 4 cycles with cnt_en=1 -> every counter reads 4.
Overflow, SATURATE=0: counter 2 driven 260 events -> reads 4, ovf_flags=4'b0100. Repeat with SATURATE=1 -> reads 255, same flag. clear -> value 0, flags 0.
Snapshot atomicity: counter 0 at 20 with evt_in[0]=1, assert snap+clear same cycle -> shadow0 reads 20 (rd_src=1), live0 reads 0 then counts 1; snap_valid=1.
Edge cases: rd_idx=6 with NUM_CNT=4 -> rd_data=0, rd_valid=1. clear with evt_in=all-ones -> all 0. Assert rst_n low mid-count and during rd_en -> all outputs 0 immediately, without waiting for clk.
PERF_CNT_IRQ_EN: irq_mask=4'b0100, overflow counter 2 -> ovf_irq rises one cycle after ovf_flags[2]. Overflow counter 1 only -> ovf_irq stays 0.
